// File: rtl/vend_core_n_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_core_n_pkg : coin encodings, nickel values and FSM states shared by    |
// |                   the vending core and its change generator.                |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package vend_core_n_pkg;

  localparam logic [2:0] COIN_NICKEL  = 3'd0;
  localparam logic [2:0] COIN_DIME    = 3'd1;
  localparam logic [2:0] COIN_QUARTER = 3'd2;
  localparam logic [2:0] COIN_FIFTY   = 3'd3;
  localparam logic [2:0] COIN_DOLLAR  = 3'd4;
  localparam logic [2:0] COIN_FIVE    = 3'd5;

  localparam logic [6:0] VAL_NICKEL  = 7'd1;
  localparam logic [6:0] VAL_DIME    = 7'd2;
  localparam logic [6:0] VAL_QUARTER = 7'd5;
  localparam logic [6:0] VAL_FIFTY   = 7'd10;
  localparam logic [6:0] VAL_DOLLAR  = 7'd20;
  localparam logic [6:0] VAL_FIVE    = 7'd100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } vend_state_t;

  // Invalid encodings map to zero; callers must also consult coinIsValid.
  function automatic logic [6:0] coinValue(input logic [2:0] sel);
    logic [6:0] v;
    case (sel)
      COIN_NICKEL:  v = VAL_NICKEL;
      COIN_DIME:    v = VAL_DIME;
      COIN_QUARTER: v = VAL_QUARTER;
      COIN_FIFTY:   v = VAL_FIFTY;
      COIN_DOLLAR:  v = VAL_DOLLAR;
      COIN_FIVE:    v = VAL_FIVE;
      default:      v = 7'd0;
    endcase
    return v;
  endfunction

  function automatic logic coinIsValid(input logic [2:0] sel);
    return sel <= COIN_FIVE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_change_gen : picks the largest returnable coin not exceeding credit    |
// |                   and gates the change handshake.                           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module vend_change_gen
  import vend_core_n_pkg::*;
#(
  parameter int CREDIT_W = 10
) (
  input  logic [CREDIT_W-1:0] credit,
  input  logic                active,
  input  logic                chg_ready,
  output logic                chg_valid,
  output logic [2:0]          chg_sel,
  output logic [CREDIT_W-1:0] coinVal,
  output logic                take
);

  // Five-dollar notes are never paid out, so the dollar is the largest change coin.
  always_comb begin
    chg_sel = COIN_NICKEL;
    if (credit >= CREDIT_W'(VAL_DOLLAR))       chg_sel = COIN_DOLLAR;
    else if (credit >= CREDIT_W'(VAL_FIFTY))   chg_sel = COIN_FIFTY;
    else if (credit >= CREDIT_W'(VAL_QUARTER)) chg_sel = COIN_QUARTER;
    else if (credit >= CREDIT_W'(VAL_DIME))    chg_sel = COIN_DIME;
  end

  assign coinVal   = CREDIT_W'(coinValue(chg_sel));
  assign chg_valid = active && (credit != '0);
  assign take      = chg_valid && chg_ready;

endmodule
`default_nettype wire

// File: rtl/vend_core_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vend_core_n : N-slot vending core - credit accumulator, dispense timer and  |
// |               greedy change-return FSM. Optional VEND_STOCK_TRACK_EN adds   |
// |               per-slot stock counters and a restock input.                  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module vend_core_n
  import vend_core_n_pkg::*;
#(
  parameter int NUM_SLOTS  = 9,
  parameter int CREDIT_W   = 10,
  parameter int MAX_CREDIT = 400,
  parameter int DISP_CYC   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_valid,
  input  logic [2:0]                    coin_sel,
  input  logic [NUM_SLOTS-1:0]          slot_req,
  input  logic                          cancel,
  input  logic [NUM_SLOTS*CREDIT_W-1:0] price_flat,
`ifdef VEND_STOCK_TRACK_EN
  input  logic [NUM_SLOTS-1:0]          restock,
`endif
  output logic [CREDIT_W-1:0]           credit,
  output logic [NUM_SLOTS-1:0]          slot_ok,
  output logic [NUM_SLOTS-1:0]          slot_short,
  output logic [NUM_SLOTS-1:0]          dispense,
  output logic                          coin_reject,
  output logic                          chg_valid,
  output logic [2:0]                    chg_sel,
  input  logic                          chg_ready,
  output logic                          busy
);

  localparam int                  c_cntW      = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
  localparam logic [c_cntW-1:0]   c_dispLast  = c_cntW'(DISP_CYC - 1);
  localparam logic [CREDIT_W:0]   c_maxCredit = (CREDIT_W + 1)'(MAX_CREDIT);

  vend_state_t          r_state, w_nextState;
  logic [CREDIT_W-1:0]  r_credit, w_creditNext;
  logic [NUM_SLOTS-1:0] r_dispense, w_dispenseNext;
  logic [c_cntW-1:0]    r_dispCnt, w_dispCntNext;
  logic                 r_coinReject, w_coinRejectNext;

  logic [6:0]           w_coinVal;
  logic [CREDIT_W:0]    w_coinSum;
  logic                 w_coinFits;
  logic [CREDIT_W-1:0]  w_reqPrice;
  logic [NUM_SLOTS-1:0] w_inStock;
  logic                 w_vend;
  logic [CREDIT_W-1:0]  w_chgVal;
  logic                 w_chgTake;

  assign w_coinVal  = coinValue(coin_sel);
  assign w_coinSum  = {1'b0, r_credit} + (CREDIT_W + 1)'(w_coinVal);
  assign w_coinFits = coinIsValid(coin_sel) && (w_coinSum <= c_maxCredit);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slot_ok[i] = (r_credit >= price_flat[i*CREDIT_W +: CREDIT_W]) && w_inStock[i];
  end
  assign slot_short = ~slot_ok;

  // AND-OR price mux; only meaningful when slot_req is one-hot.
  always_comb begin
    w_reqPrice = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_req[i]) w_reqPrice = w_reqPrice | price_flat[i*CREDIT_W +: CREDIT_W];
  end

  assign w_vend = (r_state == ST_IDLE) && $onehot(slot_req) && ((slot_req & slot_ok) != '0);

`ifdef VEND_STOCK_TRACK_EN
  logic [NUM_SLOTS-1:0][3:0] r_stock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stock <= {NUM_SLOTS{4'hF}};
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (restock[i])                 r_stock[i] <= 4'hF;
        else if (w_vend && slot_req[i]) r_stock[i] <= r_stock[i] - 4'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_stock
    assign w_inStock[i] = (r_stock[i] != 4'd0);
  end
`else
  assign w_inStock = '1;
`endif

  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_changeGen (
    .credit    (r_credit),
    .active    (r_state == ST_CHANGE),
    .chg_ready (chg_ready),
    .chg_valid (chg_valid),
    .chg_sel   (chg_sel),
    .coinVal   (w_chgVal),
    .take      (w_chgTake)
  );

  always_comb begin
    w_nextState      = r_state;
    w_creditNext     = r_credit;
    w_dispenseNext   = r_dispense;
    w_dispCntNext    = r_dispCnt;
    w_coinRejectNext = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (coin_valid) begin
          if (w_coinFits) w_creditNext = w_coinSum[CREDIT_W-1:0];
          else            w_coinRejectNext = 1'b1;
        end
        // Request is judged on pre-coin credit, so the subtraction cannot underflow.
        if (w_vend) begin
          w_creditNext   = w_creditNext - w_reqPrice;
          w_dispenseNext = slot_req;
          w_dispCntNext  = '0;
          w_nextState    = ST_DISPENSE;
        end else if (cancel && (r_credit != '0)) begin
          w_nextState = ST_CHANGE;
        end
      end
      ST_DISPENSE: begin
        w_coinRejectNext = coin_valid;
        if (r_dispCnt == c_dispLast) begin
          w_dispenseNext = '0;
          if (r_credit != '0) w_nextState = ST_CHANGE;
          else                w_nextState = ST_IDLE;
        end else begin
          w_dispCntNext = r_dispCnt + c_cntW'(1);
        end
      end
      ST_CHANGE: begin
        w_coinRejectNext = coin_valid;
        if (w_chgTake) w_creditNext = r_credit - w_chgVal;
        if (w_creditNext == '0) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_credit     <= '0;
      r_dispense   <= '0;
      r_dispCnt    <= '0;
      r_coinReject <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_credit     <= w_creditNext;
      r_dispense   <= w_dispenseNext;
      r_dispCnt    <= w_dispCntNext;
      r_coinReject <= w_coinRejectNext;
    end
  end

  assign credit      = r_credit;
  assign dispense    = r_dispense;
  assign coin_reject = r_coinReject;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vend_core_n.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_vend_core_n : table vectors, directed corner sequences and randomized    |
// |                  transactions against a transaction-level money model.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_vend_core_n;

  localparam int NS   = 9;
  localparam int CW   = 10;
  localparam int MAXC = 400;
  localparam int DC   = 4;
`ifdef VEND_STOCK_TRACK_EN
  localparam bit STOCK = 1'b1;
`else
  localparam bit STOCK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             coin_valid;
  logic [2:0]       coin_sel;
  logic [NS-1:0]    slot_req;
  logic             cancel;
  logic [NS*CW-1:0] price_flat;
  logic [CW-1:0]    credit;
  logic [NS-1:0]    slot_ok, slot_short, dispense;
  logic             coin_reject, chg_valid, chg_ready, busy;
  logic [2:0]       chg_sel;
`ifdef VEND_STOCK_TRACK_EN
  logic [NS-1:0]    restock;
`endif

  vend_core_n #(
    .NUM_SLOTS(NS), .CREDIT_W(CW), .MAX_CREDIT(MAXC), .DISP_CYC(DC)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .slot_req(slot_req), .cancel(cancel), .price_flat(price_flat),
`ifdef VEND_STOCK_TRACK_EN
    .restock(restock),
`endif
    .credit(credit), .slot_ok(slot_ok), .slot_short(slot_short),
    .dispense(dispense), .coin_reject(coin_reject), .chg_valid(chg_valid),
    .chg_sel(chg_sel), .chg_ready(chg_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    int         expCredit;
    logic       expReject;
  } coinVec_t;

  coinVec_t      tbl [17];
  int            coinVal [8] = '{1, 2, 5, 10, 20, 100, 0, 0};
  int            mCredit;
  int            mPrice [NS];
  int            mStock [NS];
  int            expCoins [$];
  int            gotCoins [$];
  int            dispCycles;
  logic [NS-1:0] dispMask;
  int            nCmp = 0;
  int            nErr = 0;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setPrices();
    for (int i = 0; i < NS; i++) price_flat[i*CW +: CW] = CW'(mPrice[i]);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mCredit = 0;
    for (int i = 0; i < NS; i++) mStock[i] = 15;
  endtask

  // Drive a one-cycle request at a negedge; returns at the next negedge.
  task automatic step(input logic cv, input logic [2:0] cs, input logic [NS-1:0] sr, input logic cn);
    coin_valid = cv; coin_sel = cs; slot_req = sr; cancel = cn;
    @(negedge clk);
    coin_valid = 1'b0; coin_sel = 3'd0; slot_req = '0; cancel = 1'b0;
  endtask

  // Greedy change from the coin denominations, largest first.
  function automatic void greedy(input int c);
    int v;
    expCoins.delete();
    while (c > 0) begin
      if (c >= 20)      v = 20;
      else if (c >= 10) v = 10;
      else if (c >= 5)  v = 5;
      else if (c >= 2)  v = 2;
      else              v = 1;
      expCoins.push_back(v);
      c -= v;
    end
  endfunction

  task automatic runToIdle(input bit stall);
    int guard = 0;
    int heldSel = -1;
    dispCycles = 0;
    dispMask = '0;
    gotCoins.delete();
    while (busy && guard < 2000) begin
      if (dispense != '0) begin
        dispCycles++;
        dispMask |= dispense;
      end
      if (chg_valid && heldSel >= 0) check("chg_sel_hold", int'(chg_sel), heldSel);
      chg_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (chg_valid && chg_ready) gotCoins.push_back(coinVal[chg_sel]);
      heldSel = (chg_valid && !chg_ready) ? int'(chg_sel) : -1;
      @(negedge clk);
      guard++;
    end
    chg_ready = 1'b0;
    if (guard >= 2000) check("idle_timeout", guard, 0);
  endtask

  task automatic expectTxn(input string tag, input logic [NS-1:0] expMask, input int expDisp);
    check({tag, "_disp_cycles"}, dispCycles, expDisp);
    check({tag, "_disp_mask"}, int'(dispMask), int'(expMask));
    check({tag, "_coin_count"}, gotCoins.size(), expCoins.size());
    for (int k = 0; k < expCoins.size() && k < gotCoins.size(); k++)
      check({tag, "_coin"}, gotCoins[k], expCoins[k]);
    check({tag, "_credit"}, int'(credit), mCredit);
    check({tag, "_chg_valid_idle"}, int'(chg_valid), 0);
  endtask

  task automatic opCoin(input logic [2:0] sel);
    bit ok;
    ok = (sel < 3'd6) && (mCredit + coinVal[sel] <= MAXC);
    step(1'b1, sel, '0, 1'b0);
    if (ok) mCredit += coinVal[sel];
    check("coin_reject", int'(coin_reject), int'(!ok));
    check("coin_credit", int'(credit), mCredit);
  endtask

  task automatic opVend(input logic [NS-1:0] mask);
    bit ok;
    int idx = 0;
    ok = $onehot(mask);
    for (int i = 0; i < NS; i++) if (mask[i]) idx = i;
    if (ok) ok = (mCredit >= mPrice[idx]) && (mStock[idx] > 0);
    step(1'b0, 3'd0, mask, 1'b0);
    if (ok) begin
      mCredit -= mPrice[idx];
      if (STOCK) mStock[idx]--;
      greedy(mCredit);
    end else begin
      expCoins.delete();
    end
    runToIdle(1'b1);
    if (ok) mCredit = 0;
    expectTxn("vend", ok ? mask : '0, ok ? DC : 0);
  endtask

  task automatic opCancel();
    greedy(mCredit);
    step(1'b0, 3'd0, '0, 1'b1);
    runToIdle(1'b1);
    mCredit = 0;
    expectTxn("cancel", '0, 0);
  endtask

  task automatic checkLeds();
    bit e;
    for (int i = 0; i < NS; i++) begin
      e = (mCredit >= mPrice[i]) && (mStock[i] > 0);
      check("slot_ok", int'(slot_ok[i]), int'(e));
      check("slot_short", int'(slot_short[i]), int'(!e));
    end
  endtask

  initial begin
    rst = 1'b0; coin_valid = 1'b0; coin_sel = 3'd0; slot_req = '0; cancel = 1'b0;
    chg_ready = 1'b0; price_flat = '0;
`ifdef VEND_STOCK_TRACK_EN
    restock = '0;
`endif
    for (int i = 0; i < NS; i++) mPrice[i] = 15 + 5 * i;
    setPrices();

    tbl[0]  = '{sel: 3'd1, expCredit: 2,   expReject: 1'b0};
    tbl[1]  = '{sel: 3'd6, expCredit: 2,   expReject: 1'b1};
    tbl[2]  = '{sel: 3'd2, expCredit: 7,   expReject: 1'b0};
    tbl[3]  = '{sel: 3'd7, expCredit: 7,   expReject: 1'b1};
    tbl[4]  = '{sel: 3'd5, expCredit: 107, expReject: 1'b0};
    tbl[5]  = '{sel: 3'd5, expCredit: 207, expReject: 1'b0};
    tbl[6]  = '{sel: 3'd5, expCredit: 307, expReject: 1'b0};
    tbl[7]  = '{sel: 3'd3, expCredit: 317, expReject: 1'b0};
    tbl[8]  = '{sel: 3'd4, expCredit: 337, expReject: 1'b0};
    tbl[9]  = '{sel: 3'd4, expCredit: 357, expReject: 1'b0};
    tbl[10] = '{sel: 3'd4, expCredit: 377, expReject: 1'b0};
    tbl[11] = '{sel: 3'd4, expCredit: 397, expReject: 1'b0};
    tbl[12] = '{sel: 3'd2, expCredit: 397, expReject: 1'b1};
    tbl[13] = '{sel: 3'd1, expCredit: 399, expReject: 1'b0};
    tbl[14] = '{sel: 3'd0, expCredit: 400, expReject: 1'b0};
    tbl[15] = '{sel: 3'd0, expCredit: 400, expReject: 1'b1};
    tbl[16] = '{sel: 3'd5, expCredit: 400, expReject: 1'b1};

    doReset();
    check("rst_credit", int'(credit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_chg_valid", int'(chg_valid), 0);
    check("rst_dispense", int'(dispense), 0);
    check("rst_coin_reject", int'(coin_reject), 0);

    // Coin acceptance and the MAX_CREDIT ceiling
    for (int k = 0; k < 17; k++) begin
      step(1'b1, tbl[k].sel, '0, 1'b0);
      check("tbl_credit", int'(credit), tbl[k].expCredit);
      check("tbl_reject", int'(coin_reject), int'(tbl[k].expReject));
    end
    mCredit = 400;
    @(negedge clk);
    check("reject_pulse_end", int'(coin_reject), 0);
    opCancel();

    // Short credit, then a vend with greedy change of 9
    opCoin(3'd1);
    opCoin(3'd1);
    opVend(9'b1);
    check("short_slot0", int'(slot_short[0]), 1);
    checkLeds();
    opCoin(3'd4);
    check("credit_24", int'(credit), 24);
    opVend(9'b1);
    check("chg9_n", gotCoins.size(), 3);

    // Same-cycle coin + request: judged on pre-coin credit
    opCoin(3'd3); opCoin(3'd1); opCoin(3'd1);
    step(1'b1, 3'd0, 9'b1, 1'b0);
    mCredit = 15;
    check("coinreq_busy", int'(busy), 0);
    check("coinreq_credit", int'(credit), 15);
    step(1'b1, 3'd1, 9'b1, 1'b0);
    mCredit = 2;
    if (STOCK) mStock[0]--;
    greedy(mCredit);
    runToIdle(1'b0);
    mCredit = 0;
    expectTxn("coin_slot", 9'b1, DC);

    // Same-cycle cancel + request: request wins
    opCoin(3'd4);
    step(1'b0, 3'd0, 9'b1, 1'b1);
    mCredit = 5;
    if (STOCK) mStock[0]--;
    greedy(mCredit);
    runToIdle(1'b0);
    mCredit = 0;
    expectTxn("cancel_slot", 9'b1, DC);
    step(1'b0, 3'd0, '0, 1'b1);
    check("cancel_zero_busy", int'(busy), 0);

    // Credit 33 with the consumer stalled
    opCoin(3'd4); opCoin(3'd3); opCoin(3'd1); opCoin(3'd0);
    step(1'b0, 3'd0, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", int'(chg_valid), 1);
      check("stall_sel", int'(chg_sel), 4);
      check("stall_credit", int'(credit), 33);
      @(negedge clk);
    end
    expCoins = '{20, 10, 2, 1};
    runToIdle(1'b0);
    mCredit = 0;
    expectTxn("stall33", '0, 0);

    // Multi-hot request ignored; reset mid-change
    opCoin(3'd4); opCoin(3'd4);
    step(1'b0, 3'd0, 9'b11, 1'b0);
    check("multihot_busy", int'(busy), 0);
    check("multihot_disp", int'(dispense), 0);
    check("multihot_credit", int'(credit), 40);
    step(1'b0, 3'd0, '0, 1'b1);
    chg_ready = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_credit", int'(credit), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_chg_valid", int'(chg_valid), 0);
    check("arst_dispense", int'(dispense), 0);
    check("arst_coin_reject", int'(coin_reject), 0);
    chg_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mCredit = 0;
    for (int i = 0; i < NS; i++) mStock[i] = 15;

`ifdef VEND_STOCK_TRACK_EN
    mPrice[2] = 1;
    setPrices();
    for (int k = 0; k < 15; k++) begin
      opCoin(3'd0);
      opVend(9'b100);
    end
    opCoin(3'd0);
    check("stock_short2", int'(slot_short[2]), 1);
    check("stock_ok2", int'(slot_ok[2]), 0);
    opVend(9'b100);
    restock[2] = 1'b1;
    @(negedge clk);
    restock = '0;
    mStock[2] = 15;
    check("restock_ok2", int'(slot_ok[2]), 1);
    checkLeds();
    opCancel();
`endif

    // Randomized transactions
    for (int i = 0; i < NS; i++) mPrice[i] = $urandom_range(1, 80);
    setPrices();
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 8);
      if (op <= 5) opCoin(3'($urandom_range(0, 7)));
      else if (op <= 7) begin
        if ($urandom_range(0, 4) == 0) opVend(NS'($urandom_range(0, (1 << NS) - 1)));
        else opVend(NS'(1) << $urandom_range(0, NS - 1));
      end else opCancel();
      checkLeds();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
